// File: rtl/bp_pkg.sv
// Shared defaults, index/tag width helpers and counter constants for the
// branch predictor.
package bp_pkg;

  localparam int ENTRIES_DEF  = 16;
  localparam int CTR_BITS_DEF = 2;
  localparam int PC_W_DEF     = 32;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // pc[1:0] are dropped, so the tag starts two bits above the index
  function automatic int tag_w(input int pc_w, input int entries);
    return pc_w - $clog2(entries) - 2;
  endfunction

  function automatic int ctr_reset_val(input int ctr_bits);
    return (2 ** (ctr_bits - 1)) - 1;
  endfunction

  function automatic int ctr_alloc_val(input int ctr_bits);
    return 2 ** (ctr_bits - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for a CTR_BITS-wide saturating up/down counter.
module sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_BITS = CTR_BITS_DEF
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                inc_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != {CTR_BITS{1'b1}}) ctr_o = ctr_i + 1'b1;
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters; combinational lookup,
// single-cycle update and branch/mispredict statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = ENTRIES_DEF,
  parameter int CTR_BITS = CTR_BITS_DEF,
  parameter int PC_W     = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lk_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            up_valid,
  input  logic [PC_W-1:0] up_pc,
  input  logic            up_taken,
  input  logic [PC_W-1:0] up_target,
  input  logic            up_mispred,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispreds
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(PC_W, ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_BITS'(ctr_reset_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(ctr_alloc_val(CTR_BITS));

  logic                valid_q [ENTRIES];
  logic [TAG_W-1:0]    tag_q   [ENTRIES];
  logic [PC_W-1:0]     tgt_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
  logic [31:0]         branches_q, mispreds_q;

  logic [IDX_W-1:0]    lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic                up_hit;
  logic [CTR_BITS-1:0] ctr_d;
  logic                unused_pc_lsbs;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[PC_W-1:IDX_W+2];
  assign up_idx = up_pc[IDX_W+1:2];
  assign up_tag = up_pc[PC_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{lk_pc[1:0], up_pc[1:0]};

  // Lookup reads current state only; a same-cycle update is not bypassed
  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target = pred_hit ? tgt_q[lk_idx] : '0;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
    .ctr_i (ctr_q[up_idx]),
    .inc_i (up_taken),
    .ctr_o (ctr_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_RST;
      end
      branches_q <= '0;
      mispreds_q <= '0;
    end else if (up_valid) begin
      branches_q <= branches_q + 32'd1;
      if (up_mispred) mispreds_q <= mispreds_q + 32'd1;
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_d;
        if (up_taken) tgt_q[up_idx] <= up_target;
      end else if (up_taken) begin
        // Allocation evicts whatever occupied this index
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= up_target;
        ctr_q[up_idx]   <= CTR_ALLOC;
      end
    end
  end

  assign stat_branches = branches_q;
  assign stat_mispreds = mispreds_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with default parameters.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lk_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        up_valid, up_taken, up_mispred;
  logic [31:0] up_pc, up_target;
  logic [31:0] stat_branches, stat_mispreds;

  int n_chk = 0;
  int n_pass = 0;

  branch_predictor dut (
    .clk           (clk),
    .reset         (reset),
    .lk_pc         (lk_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .up_valid      (up_valid),
    .up_pc         (up_pc),
    .up_taken      (up_taken),
    .up_target     (up_target),
    .up_mispred    (up_mispred),
    .stat_branches (stat_branches),
    .stat_mispreds (stat_mispreds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mp);
    up_valid = 1'b1; up_pc = pc; up_taken = tk; up_target = tgt; up_mispred = mp;
    step();
    up_valid = 1'b0; up_mispred = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    lk_pc = pc;
    #1;
    chk({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
    chk({tag, "_tgt"}, pred_target, tgt);
  endtask

  initial begin
    reset = 1'b1; lk_pc = '0;
    up_valid = 1'b0; up_pc = '0; up_taken = 1'b0; up_target = '0; up_mispred = 1'b0;
    step();
    // Update offered during reset must be dropped
    upd(32'h0040_0010, 1'b1, 32'h0040_0999, 1'b1);
    look("rst_during", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    step();
    look("rst_after", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    chk("rst_br", stat_branches, 32'd0);
    chk("rst_mp", stat_mispreds, 32'd0);

    // Allocate, then one not-taken: counter 2 -> 1
    upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    look("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 1'b0, 32'h0040_0777, 1'b1);
    look("nt_once", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);

    // Saturation: 5 taken -> 3, one NT -> 2, one T -> 3, four NT -> 0
    for (int i = 0; i < 5; i++) upd(32'h0040_0030, 1'b1, 32'h0040_0300, 1'b0);
    look("sat_hi", 32'h0040_0030, 1'b1, 1'b1, 32'h0040_0300);
    upd(32'h0040_0030, 1'b0, 32'h0, 1'b0);
    look("sat_hi_m1", 32'h0040_0030, 1'b1, 1'b1, 32'h0040_0300);
    upd(32'h0040_0030, 1'b1, 32'h0040_0300, 1'b0);
    upd(32'h0040_0030, 1'b0, 32'h0, 1'b0);
    upd(32'h0040_0030, 1'b0, 32'h0, 1'b0);
    look("ctr1", 32'h0040_0030, 1'b1, 1'b0, 32'h0040_0300);
    upd(32'h0040_0030, 1'b0, 32'h0, 1'b0);
    upd(32'h0040_0030, 1'b0, 32'h0, 1'b0);
    look("sat_lo", 32'h0040_0030, 1'b1, 1'b0, 32'h0040_0300);
    // From 0, one taken reaches 1 (still not-taken); wrap to 3 would show taken
    upd(32'h0040_0030, 1'b1, 32'h0040_0400, 1'b0);
    look("no_underflow", 32'h0040_0030, 1'b1, 1'b0, 32'h0040_0400);

    // Alias at index 4 evicts 0x0040_0010
    upd(32'h0040_0050, 1'b1, 32'h0040_0200, 1'b1);
    look("evicted", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
    look("alias", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200);

    // Miss + not-taken leaves the table alone
    upd(32'h0040_0070, 1'b0, 32'h0040_0abc, 1'b0);
    look("miss_nt", 32'h0040_0070, 1'b0, 1'b0, 32'h0);
    look("miss_nt_keep", 32'h0040_0030, 1'b1, 1'b0, 32'h0040_0400);

    // Same-cycle lookup and allocation: no bypass
    lk_pc = 32'h0040_0020;
    up_valid = 1'b1; up_pc = 32'h0040_0020; up_taken = 1'b1;
    up_target = 32'h0040_0500; up_mispred = 1'b0;
    #1;
    chk("same_cyc_pre", {31'd0, pred_hit}, 32'd0);
    step();
    up_valid = 1'b0;
    #1;
    chk("same_cyc_post", {31'd0, pred_hit}, 32'd1);

    // Mispredict without valid is ignored
    up_mispred = 1'b1;
    step();
    up_mispred = 1'b0;
    chk("stat_br", stat_branches, 32'd17);
    chk("stat_mp", stat_mispreds, 32'd2);

    // Burst of 10 taken updates; reset lands on update 5
    for (int i = 0; i < 10; i++) begin
      up_valid = 1'b1; up_pc = 32'h0040_0000 + 32'(i * 4); up_taken = 1'b1;
      up_target = 32'h0050_0000 + 32'(i); up_mispred = (i == 1 || i == 2 || i == 4 || i == 7);
      reset = (i == 5);
      step();
      reset = 1'b0;
      if (i == 5) begin
        chk("burst_rst_br", stat_branches, 32'd0);
        chk("burst_rst_mp", stat_mispreds, 32'd0);
        look("burst_old0", 32'h0040_0000, 1'b0, 1'b0, 32'h0);
        look("burst_old4", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
        look("burst_old_c", 32'h0040_0030, 1'b0, 1'b0, 32'h0);
      end
    end
    up_valid = 1'b0; up_mispred = 1'b0;
    #1;
    chk("burst_br", stat_branches, 32'd4);
    chk("burst_mp", stat_mispreds, 32'd1);
    look("burst_rstcyc", 32'h0040_0014, 1'b0, 1'b0, 32'h0);
    look("burst_new8", 32'h0040_0020, 1'b1, 1'b1, 32'h0050_0008);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
